branch_resolve_predict: RTL and testbench

Parametrised branch resolution unit with an integrated branch history table (BHT) of 2-bit saturating counters. It sits between fetch and execute:
- Fetch reads a taken/not-taken prediction combinationally.
- Execute resolves the actual condition from the ALU flags.
- The block trains the BHT and raises a registered one-cycle mispredict pulse for the pipeline flush logic.

Saturating statistics counters for resolved branches and mispredicts are included for performance debug.

---
 rtl/branch_resolve_predict.sv | 117 +++++++++++
 tb/tb_branch_resolve_predict.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_predict.sv
// Branch resolution unit with a 2-bit saturating-counter BHT, registered
// mispredict pulse and saturating branch/mispredict statistics.
module branch_resolve_predict #(
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned PC_W      = 16,
    parameter logic [1:0]  CTR_INIT  = 2'b01,
    parameter int unsigned CNT_W     = 16,
    parameter bit          OVF_AWARE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  f_pc,
    output logic             f_pred_taken,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [3:0]       ex_op,
    input  logic             ex_pred_taken,
    input  logic             SF,
    input  logic             ZF,
    input  logic             OF,
    input  logic             CF,
    output logic             brchcnd,
    output logic             setrd,
    output logic             mispredict,
    output logic             mp_taken,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    localparam logic [3:0] OP_BEQZ = 4'd1;
    localparam logic [3:0] OP_BNEZ = 4'd2;
    localparam logic [3:0] OP_BLTZ = 4'd3;
    localparam logic [3:0] OP_BGEZ = 4'd4;
    localparam logic [3:0] OP_JUMP = 4'd5;
    localparam logic [3:0] OP_SEQ  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLE  = 4'd8;
    localparam logic [3:0] OP_SCO  = 4'd9;

    logic [1:0]       bht_q [DEPTH];
    logic             mispredict_q, mp_taken_q;
    logic [CNT_W-1:0] br_count_q, mp_count_q;

    logic             lt_c, is_cond_c, is_jump_c, mp_event_c;
    logic [IDX_W-1:0] f_idx, ex_idx;

    // PC bit 0 and the bits above the index only feed aliasing; fold them away.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc, ex_pc};

    assign f_idx        = f_pc[IDX_W:1];
    assign ex_idx       = ex_pc[IDX_W:1];
    assign f_pred_taken = bht_q[f_idx][1];

    assign lt_c = OVF_AWARE ? (SF ^ OF) : SF;

    // Condition evaluation, fully gated by ex_valid.
    always_comb begin
        brchcnd   = 1'b0;
        setrd     = 1'b0;
        is_cond_c = 1'b0;
        is_jump_c = 1'b0;
        if (ex_valid) begin
            unique case (ex_op)
                OP_BEQZ: begin brchcnd = ZF;        is_cond_c = 1'b1; end
                OP_BNEZ: begin brchcnd = ~ZF;       is_cond_c = 1'b1; end
                OP_BLTZ: begin brchcnd = SF;        is_cond_c = 1'b1; end
                OP_BGEZ: begin brchcnd = ZF | ~SF;  is_cond_c = 1'b1; end
                OP_JUMP: begin brchcnd = 1'b1;      is_jump_c = 1'b1; end
                OP_SEQ:  setrd = ZF;
                OP_SLT:  setrd = lt_c;
                OP_SLE:  setrd = lt_c | ZF;
                OP_SCO:  setrd = CF;
                default: ;
            endcase
        end
    end

    assign mp_event_c = (is_cond_c | is_jump_c) & (ex_pred_taken != brchcnd);

    // Reset wins over a simultaneous resolve: no training, no pulse, no count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bht_q[i] <= CTR_INIT;
            end
            mispredict_q <= 1'b0;
            mp_taken_q   <= 1'b0;
            br_count_q   <= '0;
            mp_count_q   <= '0;
        end else begin
            if (is_cond_c) begin
                if (brchcnd && (bht_q[ex_idx] != 2'b11)) begin
                    bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
                end else if (!brchcnd && (bht_q[ex_idx] != 2'b00)) begin
                    bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
                end
                if (br_count_q != '1) begin
                    br_count_q <= br_count_q + CNT_W'(1);
                end
            end
            mispredict_q <= mp_event_c;
            mp_taken_q   <= brchcnd;
            if (mp_event_c && (mp_count_q != '1)) begin
                mp_count_q <= mp_count_q + CNT_W'(1);
            end
        end
    end

    assign mispredict = mispredict_q;
    assign mp_taken   = mp_taken_q;
    assign br_count   = br_count_q;
    assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench: three instances (default, overflow-aware compares, 4-bit
// statistics) share stimulus and are checked against a behavioural model.
module tb_branch_resolve_predict;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_BEQZ = 4'd1;
    localparam logic [3:0] OP_BNEZ = 4'd2;
    localparam logic [3:0] OP_BLTZ = 4'd3;
    localparam logic [3:0] OP_BGEZ = 4'd4;
    localparam logic [3:0] OP_JUMP = 4'd5;
    localparam logic [3:0] OP_SEQ  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLE  = 4'd8;
    localparam logic [3:0] OP_SCO  = 4'd9;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] f_pc, ex_pc;
    logic        ex_valid, ex_pred;
    logic [3:0]  ex_op;
    logic        sf_t, zf_t, of_t, cf_t;

    logic        fp0, br0, sr0, mp0, mpt0;
    logic        fp1, br1, sr1, mp1, mpt1;
    logic        fp2, br2, sr2, mp2, mpt2;
    logic [15:0] bc0, mc0, bc1, mc1;
    logic [3:0]  bc2, mc2;

    branch_resolve_predict dut0 (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(fp0),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_pred_taken(ex_pred),
        .SF(sf_t), .ZF(zf_t), .OF(of_t), .CF(cf_t),
        .brchcnd(br0), .setrd(sr0), .mispredict(mp0), .mp_taken(mpt0),
        .br_count(bc0), .mp_count(mc0));

    branch_resolve_predict #(.OVF_AWARE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(fp1),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_pred_taken(ex_pred),
        .SF(sf_t), .ZF(zf_t), .OF(of_t), .CF(cf_t),
        .brchcnd(br1), .setrd(sr1), .mispredict(mp1), .mp_taken(mpt1),
        .br_count(bc1), .mp_count(mc1));

    branch_resolve_predict #(.CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(fp2),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_pred_taken(ex_pred),
        .SF(sf_t), .ZF(zf_t), .OF(of_t), .CF(cf_t),
        .brchcnd(br2), .setrd(sr2), .mispredict(mp2), .mp_taken(mpt2),
        .br_count(bc2), .mp_count(mc2));

    int vectors = 0;
    int miscompares = 0;

    // Model state: counter per table slot as a plain integer 0..3.
    int bht [16];
    bit m_mp, m_mpt, cmp_en;
    int m_br16, m_mp16, m_br4, m_mp4;

    function automatic bit exp_brch(input logic [3:0] op, input bit v, input bit z, input bit s);
        if (!v) return 1'b0;
        case (op)
            OP_JUMP: return 1'b1;
            OP_BEQZ: return z;
            OP_BNEZ: return !z;
            OP_BLTZ: return s;
            OP_BGEZ: return z || !s;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_set(input logic [3:0] op, input bit v, input bit z, input bit s,
                                   input bit o, input bit c, input bit ovf);
        bit lt;
        lt = ovf ? (s != o) : s;
        if (!v) return 1'b0;
        case (op)
            OP_SEQ:  return z;
            OP_SLT:  return lt;
            OP_SLE:  return lt || z;
            OP_SCO:  return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat_inc(input int x, input int lim);
        return (x < lim) ? x + 1 : x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_compare();
        bit p, b;
        if (!cmp_en) return;
        p = bht[int'(f_pc[4:1])] >= 2;
        b = exp_brch(ex_op, ex_valid, zf_t, sf_t);
        chk("f_pred_taken", {fp0, fp1, fp2}, {p, p, p});
        chk("brchcnd", {br0, br1, br2}, {b, b, b});
        chk("setrd", {sr0, sr1, sr2},
            {exp_set(ex_op, ex_valid, zf_t, sf_t, of_t, cf_t, 1'b0),
             exp_set(ex_op, ex_valid, zf_t, sf_t, of_t, cf_t, 1'b1),
             exp_set(ex_op, ex_valid, zf_t, sf_t, of_t, cf_t, 1'b0)});
        chk("mispredict", {mp0, mp1, mp2}, {m_mp, m_mp, m_mp});
        if (m_mp) chk("mp_taken", {mpt0, mpt1, mpt2}, {m_mpt, m_mpt, m_mpt});
        chk("br_count16", {bc0, bc1}, {16'(m_br16), 16'(m_br16)});
        chk("mp_count16", {mc0, mc1}, {16'(m_mp16), 16'(m_mp16)});
        chk("br_count4", 32'(bc2), 32'(m_br4));
        chk("mp_count4", 32'(mc2), 32'(m_mp4));
    endtask

    task automatic model_update();
        bit b, cond, jmp, ev;
        int i;
        if (rst) begin
            for (int k = 0; k < 16; k++) bht[k] = 1;
            m_mp = 0; m_mpt = 0;
            m_br16 = 0; m_mp16 = 0; m_br4 = 0; m_mp4 = 0;
            return;
        end
        b    = exp_brch(ex_op, ex_valid, zf_t, sf_t);
        cond = ex_valid && (ex_op inside {OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ});
        jmp  = ex_valid && (ex_op == OP_JUMP);
        i    = int'(ex_pc[4:1]);
        if (cond) begin
            bht[i] = b ? ((bht[i] < 3) ? bht[i] + 1 : 3) : ((bht[i] > 0) ? bht[i] - 1 : 0);
            m_br16 = sat_inc(m_br16, 65535);
            m_br4  = sat_inc(m_br4, 15);
        end
        ev    = (cond || jmp) && (ex_pred != b);
        m_mp  = ev;
        m_mpt = b;
        if (ev) begin
            m_mp16 = sat_inc(m_mp16, 65535);
            m_mp4  = sat_inc(m_mp4, 15);
        end
    endtask

    // One clock: compare mid-cycle, advance the model at the edge, settle.
    task automatic cycle();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_update();
        cmp_en = 1'b1;
        #1;
    endtask

    task automatic ex(input logic [3:0] op, input logic [15:0] pc, input bit v, input bit pred,
                      input bit z, input bit s, input bit o, input bit c);
        ex_op = op; ex_pc = pc; ex_valid = v; ex_pred = pred;
        zf_t = z; sf_t = s; of_t = o; cf_t = c;
        #1;
    endtask

    initial begin
        cmp_en = 1'b0;
        rst = 1'b1; f_pc = 16'h0010;
        ex(OP_NONE, 16'h0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        rst = 1'b0;
        chk("rst_fpred", 32'(fp0), 0);
        chk("rst_counts", {bc0, mc0}, 0);
        chk("rst_mp", 32'(mp0), 0);

        // Taken BEQZ at 0x10 walks 01 -> 10 -> 11 -> 11.
        ex(OP_BEQZ, 16'h0010, 1, 0, 1, 0, 0, 0); cycle();
        chk("beqz1_mp", 32'(mp0), 1);
        ex(OP_BEQZ, 16'h0010, 1, 1, 1, 0, 0, 0); cycle();
        chk("beqz2_mp", 32'(mp0), 0);
        cycle();
        chk("beqz3_mp", 32'(mp0), 0);
        chk("beqz3_br", 32'(bc0), 3);
        cycle();
        // Two not-taken resolves from a saturated 11 leave it at 01.
        ex(OP_BEQZ, 16'h0010, 1, 1, 0, 0, 0, 0); cycle();
        chk("nt1_fpred", 32'(fp0), 1);
        cycle();
        chk("nt2_fpred", 32'(fp0), 0);
        chk("nt2_counts", {bc0, mc0}, {16'd6, 16'd3});

        ex(OP_JUMP, 16'h0040, 1, 0, 0, 0, 0, 0);
        chk("jump_brch", 32'(br0), 1);
        cycle();
        chk("jump_mp", {mp0, mpt0}, 2'b11);
        chk("jump_counts", {bc0, mc0}, {16'd6, 16'd4});

        ex(OP_SLT, 16'h0042, 1, 0, 0, 0, 1, 0);
        chk("slt_setrd", {sr0, sr1, br0}, 3'b010);
        cycle();
        ex(OP_SLE, 16'h0044, 1, 0, 1, 0, 1, 0);
        chk("sle_setrd", {sr0, br0}, 2'b10);
        cycle();

        // Same-cycle read and update of slot 0 (counter 01).
        f_pc = 16'h0020;
        ex(OP_BNEZ, 16'h0020, 1, 0, 0, 0, 0, 0);
        chk("haz_old", 32'(fp0), 0);
        cycle();
        chk("haz_new", 32'(fp0), 1);

        // Mixed ops, invalid slot, aliased PC 0x30 onto slot of 0x10.
        ex(OP_BLTZ, 16'h0006, 1, 0, 0, 1, 0, 0); cycle();
        ex(OP_BGEZ, 16'h0006, 1, 1, 0, 1, 0, 0); cycle();
        ex(OP_BGEZ, 16'h0008, 1, 0, 1, 1, 0, 0); cycle();
        ex(OP_SEQ,  16'h0008, 1, 1, 1, 0, 0, 1); cycle();
        ex(OP_SCO,  16'h0008, 1, 1, 0, 0, 0, 1); cycle();
        ex(OP_BEQZ, 16'h0030, 0, 0, 1, 0, 0, 0); cycle();
        ex(4'hF,    16'h0030, 1, 0, 1, 1, 1, 1); cycle();
        f_pc = 16'h0010;
        ex(OP_BEQZ, 16'h0030, 1, 0, 1, 0, 0, 0); cycle();
        cycle();

        // Reset beats a mispredicting BLTZ.
        rst = 1'b1;
        ex(OP_BLTZ, 16'h0020, 1, 0, 0, 1, 0, 0); cycle();
        rst = 1'b0;
        ex(OP_NONE, 16'h0, 0, 0, 0, 0, 0, 0);
        chk("rstmid_mp", 32'(mp0), 0);
        chk("rstmid_counts", {bc0, mc0}, 0);
        chk("rstmid_fpred", 32'(fp0), 0);

        // Saturation of the 4-bit statistics.
        for (int k = 0; k < 20; k++) begin
            ex(OP_BNEZ, 16'(k * 2), 1, 0, (k % 3) == 0, 0, 0, 0); cycle();
        end
        chk("sat_br4", 32'(bc2), 15);
        chk("sat_br16", 32'(bc0), 20);
        for (int k = 0; k < 20; k++) begin
            ex(OP_JUMP, 16'h0050, 1, 0, 0, 0, 0, 0); cycle();
        end
        chk("sat_mp4", 32'(mc2), 15);
        ex(OP_NONE, 16'h0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
